// File: rtl/mem_arb_pkg.sv
// Shared definitions for the core memory-port arbiter and the ID control block.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } arb_state_t;

    localparam int unsigned ADDR_STEP = 4;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_dm_burst_ctr.sv
// Beat counter and running address for a data burst; last_beat_o means no
// further beats remain to be issued.
module dm_burst_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BEAT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [BEAT_W-1:0] beats_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_beat_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Beat 0 is issued at the base address during the grant cycle, so the
    // register starts one step ahead with max(beats,1)-1 beats remaining.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (load_i) begin
            cnt_d  = (beats_i == '0) ? '0 : beats_i - BEAT_W'(1);
            addr_d = base_addr_i + STEP;
        end else if (step_i && (cnt_q != '0)) begin
            cnt_d  = cnt_q - BEAT_W'(1);
            addr_d = addr_q + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o      = addr_q;
    assign last_beat_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between instruction fetch and MEM-stage
// data bursts; bursts are atomic, one beat per cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BEAT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_stall,
    output logic              o_if_valid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [BEAT_W-1:0] i_dm_beats,
    input  logic [DATA_W-1:0] i_dm_wdata,
    input  logic [1:0]        i_dm_mode,
    output logic              o_dm_beat_ack,
    output logic              o_dm_stall,
    output logic              o_dm_valid,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_dm_done,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [1:0]        o_mem_mode,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    arb_state_t state_q, state_d;
    logic fetch_owed_q, fetch_owed_d;
    logic if_seen_q, if_seen_d;
    logic dm_rd_pend_q, dm_rd_pend_d;

    logic              ctr_load, ctr_step, last_beat;
    logic [ADDR_W-1:0] burst_addr;
    logic              arb_en, if_cand, dm_cand, if_issue;

    dm_burst_ctr #(
        .ADDR_W (ADDR_W),
        .BEAT_W (BEAT_W)
    ) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ctr_load),
        .step_i      (ctr_step),
        .base_addr_i (i_dm_addr),
        .beats_i     (i_dm_beats),
        .addr_o      (burst_addr),
        .last_beat_o (last_beat)
    );

    always_comb begin
        state_d       = state_q;
        fetch_owed_d  = fetch_owed_q;
        if_seen_d     = if_seen_q;
        dm_rd_pend_d  = 1'b0;
        ctr_load      = 1'b0;
        ctr_step      = 1'b0;
        arb_en        = 1'b0;
        if_cand       = 1'b0;
        dm_cand       = 1'b0;
        if_issue      = 1'b0;
        o_mem_en      = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        o_mem_mode    = '0;
        o_if_valid    = 1'b0;
        o_if_rdata    = '0;
        o_dm_valid    = 1'b0;
        o_dm_rdata    = '0;
        o_dm_done     = 1'b0;
        o_dm_beat_ack = 1'b0;
        o_if_stall    = 1'b0;
        o_dm_stall    = 1'b0;

        if (!rst) begin
            if (dm_rd_pend_q) begin
                o_dm_valid = 1'b1;
                o_dm_rdata = i_mem_rdata;
            end

            // A request is held through its own completion cycle, so the
            // requester that just completed is excluded from that cycle's
            // arbitration.
            unique case (state_q)
                IDLE: begin
                    arb_en  = 1'b1;
                    if_cand = i_if_req;
                    dm_cand = i_dm_req;
                end
                IF_BUSY: begin
                    o_if_valid = 1'b1;
                    o_if_rdata = i_mem_rdata;
                    arb_en     = 1'b1;
                    dm_cand    = i_dm_req;
                end
                DM_BUSY: begin
                    if (last_beat) begin
                        o_dm_done    = 1'b1;
                        fetch_owed_d = if_seen_q | i_if_req;
                        arb_en       = 1'b1;
                        if_cand      = i_if_req;
                    end else begin
                        if_seen_d     = if_seen_q | i_if_req;
                        o_mem_en      = 1'b1;
                        o_mem_we      = i_dm_we;
                        o_mem_addr    = burst_addr;
                        o_mem_wdata   = i_dm_wdata;
                        o_mem_mode    = i_dm_mode;
                        o_dm_beat_ack = 1'b1;
                        ctr_step      = 1'b1;
                        dm_rd_pend_d  = ~i_dm_we;
                    end
                end
                default: ;
            endcase

            if (arb_en) begin
                state_d = IDLE;
                if (dm_cand && !(if_cand && fetch_owed_q)) begin
                    o_mem_en      = 1'b1;
                    o_mem_we      = i_dm_we;
                    o_mem_addr    = i_dm_addr;
                    o_mem_wdata   = i_dm_wdata;
                    o_mem_mode    = i_dm_mode;
                    o_dm_beat_ack = 1'b1;
                    ctr_load      = 1'b1;
                    dm_rd_pend_d  = ~i_dm_we;
                    if_seen_d     = i_if_req;
                    state_d       = DM_BUSY;
                end else if (if_cand) begin
                    o_mem_en     = 1'b1;
                    o_mem_addr   = i_if_addr;
                    o_mem_mode   = MODE_WORD;
                    if_issue     = 1'b1;
                    fetch_owed_d = 1'b0;
                    state_d      = IF_BUSY;
                end
            end

            o_if_stall = i_if_req && !if_issue && !o_if_valid;
            o_dm_stall = i_dm_req && !o_dm_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_owed_q <= 1'b0;
            if_seen_q    <= 1'b0;
            dm_rd_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_owed_q <= fetch_owed_d;
            if_seen_q    <= if_seen_d;
            dm_rd_pend_q <= dm_rd_pend_d;
        end
    end

    a_if_req_held: assert property (@(posedge clk) disable iff (rst)
        (i_if_req && !o_if_valid) |=> i_if_req);
    a_dm_req_held: assert property (@(posedge clk) disable iff (rst)
        (i_dm_req && !o_dm_done) |=> i_dm_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized requesters,
// checked every cycle against a timeline model of grants and bursts.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_stall, o_if_valid;
    logic [31:0] o_if_rdata;
    logic        i_dm_req, i_dm_we;
    logic [31:0] i_dm_addr;
    logic [3:0]  i_dm_beats;
    logic [31:0] i_dm_wdata;
    logic [1:0]  i_dm_mode;
    logic        o_dm_beat_ack, o_dm_stall, o_dm_valid, o_dm_done;
    logic [31:0] o_dm_rdata;
    logic        o_mem_en, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [1:0]  o_mem_mode;
    logic [31:0] i_mem_rdata;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .BEAT_W (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_if_req      (i_if_req),
        .i_if_addr     (i_if_addr),
        .o_if_stall    (o_if_stall),
        .o_if_valid    (o_if_valid),
        .o_if_rdata    (o_if_rdata),
        .i_dm_req      (i_dm_req),
        .i_dm_we       (i_dm_we),
        .i_dm_addr     (i_dm_addr),
        .i_dm_beats    (i_dm_beats),
        .i_dm_wdata    (i_dm_wdata),
        .i_dm_mode     (i_dm_mode),
        .o_dm_beat_ack (o_dm_beat_ack),
        .o_dm_stall    (o_dm_stall),
        .o_dm_valid    (o_dm_valid),
        .o_dm_rdata    (o_dm_rdata),
        .o_dm_done     (o_dm_done),
        .o_mem_en      (o_mem_en),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_mem_mode    (o_mem_mode),
        .i_mem_rdata   (i_mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        we;
        logic        dm;
        logic        ifi;
        logic        dvalid;
        logic        ivalid;
        logic        done;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] raddr;
    } exp_t;

    exp_t ring [32];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   next_arb = 0, mask_if = -1, mask_dm = -1, burst_end = -1;
    bit   in_burst = 0, seen_if = 0, owed = 0;
    bit   prev_rd = 0, last_ivalid = 0, last_done = 0, last_ack = 0, last_rst = 0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic tick_begin();
        @(posedge clk);
        #1;
    endtask

    // Model: a grant books the whole memory timeline of its transaction
    // (issue slots, return pulses, completion) into future cycle slots.
    task automatic check_cycle();
        exp_t e;
        int   n;
        bit   if_eff, dm_eff;
        i_mem_rdata = prev_rd ? memf(prev_addr) : $urandom();
        #3;
        e = '0;
        if (rst) begin
            for (int i = 0; i < 32; i++) ring[i] = '0;
            next_arb = cyc + 1;
            owed = 0; in_burst = 0; seen_if = 0; mask_if = -1; mask_dm = -1;
        end else begin
            if (in_burst && cyc < burst_end && i_if_req) seen_if = 1;
            if (in_burst && cyc == burst_end) begin
                owed = seen_if || i_if_req;
                in_burst = 0;
            end
            if (cyc >= next_arb) begin
                if_eff = i_if_req && (mask_if != cyc);
                dm_eff = i_dm_req && (mask_dm != cyc);
                if (dm_eff && !(if_eff && owed)) begin
                    n = (i_dm_beats == 0) ? 1 : int'(i_dm_beats);
                    for (int k = 0; k < n; k++) begin
                        ring[(cyc+k)%32].en   = 1;
                        ring[(cyc+k)%32].we   = i_dm_we;
                        ring[(cyc+k)%32].dm   = 1;
                        ring[(cyc+k)%32].mode = i_dm_mode;
                        ring[(cyc+k)%32].addr = i_dm_addr + 32'(4*k);
                        if (!i_dm_we) begin
                            ring[(cyc+k+1)%32].dvalid = 1;
                            ring[(cyc+k+1)%32].raddr  = i_dm_addr + 32'(4*k);
                        end
                    end
                    ring[(cyc+n)%32].done = 1;
                    next_arb = cyc + n; mask_dm = cyc + n; burst_end = cyc + n;
                    in_burst = 1; seen_if = i_if_req;
                end else if (if_eff) begin
                    ring[cyc%32].en   = 1;
                    ring[cyc%32].ifi  = 1;
                    ring[cyc%32].mode = MODE_WORD;
                    ring[cyc%32].addr = i_if_addr;
                    ring[(cyc+1)%32].ivalid = 1;
                    ring[(cyc+1)%32].raddr  = i_if_addr;
                    next_arb = cyc + 1; mask_if = cyc + 1; owed = 0;
                end
            end
            e = ring[cyc%32];
            ring[cyc%32] = '0;
        end
        chk("mem_en",    32'(o_mem_en),      32'(e.en));
        chk("mem_we",    32'(o_mem_we),      32'(e.we));
        chk("mem_addr",  o_mem_addr,         e.en ? e.addr : 32'h0);
        chk("mem_mode",  32'(o_mem_mode),    32'(e.mode));
        chk("mem_wdata", o_mem_wdata,        e.dm ? i_dm_wdata : 32'h0);
        chk("beat_ack",  32'(o_dm_beat_ack), 32'(e.dm));
        chk("dm_valid",  32'(o_dm_valid),    32'(e.dvalid));
        chk("dm_rdata",  o_dm_rdata,         e.dvalid ? memf(e.raddr) : 32'h0);
        chk("dm_done",   32'(o_dm_done),     32'(e.done));
        chk("if_valid",  32'(o_if_valid),    32'(e.ivalid));
        chk("if_rdata",  o_if_rdata,         e.ivalid ? memf(e.raddr) : 32'h0);
        chk("if_stall",  32'(o_if_stall),    32'(!rst && i_if_req && !e.ifi && !e.ivalid));
        chk("dm_stall",  32'(o_dm_stall),    32'(!rst && i_dm_req && !e.done));
        prev_rd     = o_mem_en && !o_mem_we;
        prev_addr   = o_mem_addr;
        last_ivalid = o_if_valid;
        last_done   = o_dm_done;
        last_ack    = o_dm_beat_ack;
        last_rst    = rst;
        cyc++;
    endtask

    task automatic drive_random();
        if (last_rst) begin
            i_if_req = 0;
            i_dm_req = 0;
        end else begin
            if (i_if_req) begin
                if (last_ivalid) i_if_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                i_if_req  = 1;
                i_if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (i_dm_req) begin
                if (last_done) i_dm_req = 0;
                else if (last_ack) i_dm_wdata = $urandom();
            end else if ($urandom_range(0, 3) == 0) begin
                i_dm_req   = 1;
                i_dm_we    = 1'($urandom_range(0, 1));
                i_dm_beats = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                         : 4'($urandom_range(0, 4));
                i_dm_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                         : ($urandom() & 32'hFFFF_FFFC);
                i_dm_mode  = 2'($urandom_range(0, 2));
                i_dm_wdata = $urandom();
            end
        end
        rst = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        rst = 1; i_if_req = 0; i_if_addr = '0; i_dm_req = 0; i_dm_we = 0;
        i_dm_addr = '0; i_dm_beats = '0; i_dm_wdata = '0; i_dm_mode = '0; i_mem_rdata = '0;

        tick_begin(); check_cycle();
        tick_begin(); rst = 0; check_cycle();
        chk("rst_en",    32'(o_mem_en),   32'd0);
        chk("rst_addr",  o_mem_addr,      32'h0);
        chk("rst_stall", 32'(o_if_stall), 32'd0);

        // single fetch
        tick_begin(); i_if_req = 1; i_if_addr = 32'h100; check_cycle();
        chk("t1_en",   32'(o_mem_en), 32'd1);
        chk("t1_addr", o_mem_addr,    32'h100);
        tick_begin(); check_cycle();
        chk("t1_valid", 32'(o_if_valid), 32'd1);
        chk("t1_rdata", o_if_rdata,      32'h5A5A_5B5A);
        tick_begin(); i_if_req = 0; check_cycle();

        // 3-beat read burst
        tick_begin(); i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h2000; i_dm_beats = 4'd3;
        i_dm_mode = MODE_WORD; check_cycle();
        chk("t2_a0", o_mem_addr, 32'h2000);
        tick_begin(); check_cycle();
        chk("t2_a1", o_mem_addr, 32'h2004);
        chk("t2_r0", o_dm_rdata, 32'h5A5A_7A5A);
        tick_begin(); check_cycle();
        chk("t2_a2",    o_mem_addr,      32'h2008);
        chk("t2_nodone", 32'(o_dm_done), 32'd0);
        tick_begin(); check_cycle();
        chk("t2_done", 32'(o_dm_done),  32'd1);
        chk("t2_r2",   o_dm_rdata,      32'h5A5A_7A52);
        chk("t2_idle", 32'(o_mem_en),   32'd0);
        tick_begin(); i_dm_req = 0; check_cycle();

        // contention: data wins, fetch takes the drain cycle
        tick_begin(); i_if_req = 1; i_if_addr = 32'h300;
        i_dm_req = 1; i_dm_we = 1; i_dm_addr = 32'h400; i_dm_beats = 4'd2;
        i_dm_wdata = 32'hAAAA_0000; check_cycle();
        chk("t3_we",    32'(o_mem_we),   32'd1);
        chk("t3_a0",    o_mem_addr,      32'h400);
        chk("t3_ifst",  32'(o_if_stall), 32'd1);
        tick_begin(); i_dm_wdata = 32'hAAAA_0001; check_cycle();
        chk("t3_a1",    o_mem_addr,      32'h404);
        chk("t3_wd1",   o_mem_wdata,     32'hAAAA_0001);
        tick_begin(); check_cycle();
        chk("t3_done",  32'(o_dm_done),  32'd1);
        chk("t3_fetch", o_mem_addr,      32'h300);
        chk("t3_noist", 32'(o_if_stall), 32'd0);
        tick_begin(); i_dm_req = 0; check_cycle();
        chk("t3_ird",   o_if_rdata,      32'h5A5A_595A);
        tick_begin(); i_if_req = 0; check_cycle();

        // zero beats behaves as one
        tick_begin(); i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h500; i_dm_beats = 4'd0;
        check_cycle();
        chk("t4_a0", o_mem_addr, 32'h500);
        tick_begin(); check_cycle();
        chk("t4_done", 32'(o_dm_done), 32'd1);
        chk("t4_en",   32'(o_mem_en),  32'd0);
        tick_begin(); i_dm_req = 0; check_cycle();

        // address wrap
        tick_begin(); i_dm_req = 1; i_dm_we = 1; i_dm_addr = 32'hFFFF_FFFC; i_dm_beats = 4'd2;
        check_cycle();
        tick_begin(); check_cycle();
        chk("t5_wrap", o_mem_addr,    32'h0);
        chk("t5_en",   32'(o_mem_en), 32'd1);
        tick_begin(); check_cycle();
        tick_begin(); i_dm_req = 0; check_cycle();

        // reset mid-burst, then a fresh fetch
        tick_begin(); i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h600; i_dm_beats = 4'd4;
        check_cycle();
        tick_begin(); check_cycle();
        chk("t6_a1", o_mem_addr, 32'h604);
        tick_begin(); rst = 1; check_cycle();
        tick_begin(); rst = 0; i_dm_req = 0; check_cycle();
        chk("t6_en",   32'(o_mem_en),   32'd0);
        chk("t6_done", 32'(o_dm_done),  32'd0);
        chk("t6_dval", 32'(o_dm_valid), 32'd0);
        tick_begin(); i_if_req = 1; i_if_addr = 32'h700; check_cycle();
        chk("t6_fetch", o_mem_addr, 32'h700);
        tick_begin(); check_cycle();
        chk("t6_ival", 32'(o_if_valid), 32'd1);
        tick_begin(); i_if_req = 0; check_cycle();

        for (int t = 0; t < 3000; t++) begin
            tick_begin();
            drive_random();
            check_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
